// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for a show-ahead sync FIFO: drains BURST_LEN-entry bursts
// (or a shorter flush burst on timeout/request) onto a registered valid/ready stream.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 32,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
    parameter int BURST_LEN  = 8,
    parameter int TIMEOUT    = 64,
    parameter int TMR_WIDTH  = $clog2(TIMEOUT + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    input  logic                  fifo_empty_i,
    input  logic [ADDR_WIDTH:0]   fifo_counter_i,
    output logic                  fifo_rd_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_last_o,
    output logic [ADDR_WIDTH:0]   m_len_o,
    output logic                  busy_o
);

    // state | meaning
    // IDLE  | waiting for a full burst, a flush request or the idle timeout
    // BURST | popping beats_rem entries into the output register
    typedef enum logic {IDLE, BURST} state_t;

    localparam int CW = ADDR_WIDTH + 1;
    // A zero-width timer is illegal, so keep at least one bit when the timeout is disabled.
    localparam int TW = (TMR_WIDTH < 1) ? 1 : TMR_WIDTH;
    localparam logic [CW-1:0] BURST_LEN_C = CW'(BURST_LEN);
    localparam logic [CW-1:0] ONE_C       = CW'(1);
    localparam logic [TW-1:0] TMR_MAX     = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [CW-1:0]         beats_rem_q, beats_rem_d;
    logic [CW-1:0]         burst_len_q, burst_len_d;
    logic [CW-1:0]         m_len_q, m_len_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;

    logic                  out_free;
    logic                  full_ok;
    logic                  tmo_hit;
    logic                  start;
    logic [CW-1:0]         start_len;
    logic                  pop;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        beats_rem_d = beats_rem_q;
        burst_len_d = burst_len_q;
        m_len_d     = m_len_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        start       = 1'b0;
        start_len   = '0;
        pop         = 1'b0;

        out_free = ~m_valid_q | m_ready_i;
        full_ok  = (fifo_counter_i >= BURST_LEN_C);
        tmo_hit  = (TIMEOUT != 0) && (timer_q == TMR_MAX);

        case (state_q)
            IDLE: begin
                if (en_i && full_ok) begin
                    start     = 1'b1;
                    start_len = BURST_LEN_C;
                end else if (en_i && !fifo_empty_i && (flush_i || tmo_hit)) begin
                    start     = 1'b1;
                    start_len = fifo_counter_i;
                end

                if (start) begin
                    state_d     = BURST;
                    beats_rem_d = start_len;
                    burst_len_d = start_len;
                    timer_d     = '0;
                    // A held last beat of the previous burst keeps its own length until it is taken.
                    if (out_free) begin
                        m_len_d = start_len;
                    end
                end else if (fifo_empty_i) begin
                    timer_d = '0;
                end else if (en_i && !full_ok && (timer_q != TMR_MAX)) begin
                    timer_d = timer_q + TW'(1);
                end
            end

            BURST: begin
                timer_d = '0;
                if (out_free) begin
                    m_len_d = burst_len_q;
                end
                pop = (beats_rem_q != '0) && !fifo_empty_i && out_free;
                if (pop) begin
                    beats_rem_d = beats_rem_q - ONE_C;
                    if (beats_rem_q == ONE_C) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (pop) begin
            m_data_d  = fifo_data_i;
            m_valid_d = 1'b1;
            m_last_d  = (beats_rem_q == ONE_C);
        end else if (m_valid_q && m_ready_i) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            beats_rem_q <= '0;
            burst_len_q <= '0;
            m_len_q     <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            beats_rem_q <= beats_rem_d;
            burst_len_q <= burst_len_d;
            m_len_q     <= m_len_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
        end
    end

    assign fifo_rd_valid_o = pop;
    assign m_data_o        = m_data_q;
    assign m_valid_o       = m_valid_q;
    assign m_last_o        = m_last_q;
    assign m_len_o         = m_len_q;
    assign busy_o          = (state_q == BURST);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a small show-ahead FIFO model, a beat recorder and
// directed scenarios (reset, full burst table, timeout, backpressure, back-to-back, flush, mid-burst reset).
module tb_fifo_burst_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        m_ready_i = 1'b0;
    logic [31:0] fifo_data;
    logic        fifo_empty;
    logic [5:0]  fifo_counter;
    logic        fifo_rd_valid;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic [5:0]  m_len;
    logic        busy;

    always #5 clk = ~clk;

    fifo_burst_reader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en_i           (en_i),
        .flush_i        (flush_i),
        .fifo_data_i    (fifo_data),
        .fifo_empty_i   (fifo_empty),
        .fifo_counter_i (fifo_counter),
        .fifo_rd_valid_o(fifo_rd_valid),
        .m_data_o       (m_data),
        .m_valid_o      (m_valid),
        .m_ready_i      (m_ready_i),
        .m_last_o       (m_last),
        .m_len_o        (m_len),
        .busy_o         (busy)
    );

    // Show-ahead FIFO model owned by the bench.
    logic [31:0] mem [0:63];
    logic [5:0]  wp = '0;
    logic [5:0]  rp = '0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        fifo_clr = 1'b0;

    assign fifo_data    = mem[rp];
    assign fifo_empty   = (wp == rp);
    assign fifo_counter = wp - rp;

    always @(posedge clk) begin
        if (fifo_clr) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr_en) begin
                mem[wp] <= wr_data;
                wp      <= wp + 6'd1;
            end
            if (fifo_rd_valid) rp <= rp + 6'd1;
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [5:0]  len;
        int          cyc;
    } beat_t;
    beat_t beats[$];

    // Records each accepted beat and polices the pop rule, sampled mid-cycle.
    always @(negedge clk) begin
        #3;
        if (rst_n && m_valid && m_ready_i) beats.push_back('{m_data, m_last, m_len, cyc});
        if (fifo_rd_valid) begin
            checks++;
            if (fifo_empty || (m_valid && !m_ready_i)) begin
                errors++;
                $display("FAIL pop_rule: pop with empty=%0b m_valid=%0b m_ready=%0b, required no pop",
                         fifo_empty, m_valid, m_ready_i);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_words(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = base + 32'(i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k;
        k = 0;
        while (beats.size() < n && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (beats.size() < n) begin
            errors++;
            $display("FAIL wait_beats: got %0d beats within %0d cycles, expected %0d", beats.size(), budget, n);
        end
    endtask

    task automatic check_beats(input string name, input logic [31:0] base, input int n, input int blen);
        chk({name, "_count"}, 32'(beats.size()), 32'(n));
        for (int i = 0; i < n && i < beats.size(); i++) begin
            chk({name, "_data"}, beats[i].data, base + 32'(i));
            chk({name, "_last"}, 32'(beats[i].last), 32'((i % blen) == blen - 1));
            chk({name, "_len"}, 32'(beats[i].len), 32'(blen));
        end
    endtask

    typedef struct {
        logic        en;
        logic        ready;
        logic        busy;
        logic        rd;
        logic        valid;
        logic        last;
        logic [31:0] data;
        logic [5:0]  len;
    } vec_t;
    vec_t vt[11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Full-burst cycle table: row k holds inputs and outputs after the k-th edge from enable.
        vt[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'd0};
        vt[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 6'd8};
        for (int k = 2; k <= 8; k++)
            vt[k] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10 + 32'(k - 2), 6'd8};
        vt[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h17, 6'd8};
        vt[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h17, 6'd8};

        // 1: reset held with five entries buffered
        en_i = 1'b1;
        m_ready_i = 1'b1;
        tick();
        write_words(32'hA0, 5);
        repeat (3) tick();
        chk("rst_rd_valid", 32'(fifo_rd_valid), 32'h0);
        chk("rst_m_valid", 32'(m_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_m_data", m_data, 32'h0);
        chk("rst_fifo_count", 32'(fifo_counter), 32'd5);
        en_i = 1'b0;
        rst_n = 1'b1;
        repeat (2) tick();
        chk("post_rst_busy", 32'(busy), 32'h0);
        chk("post_rst_m_valid", 32'(m_valid), 32'h0);
        chk("post_rst_m_len", 32'(m_len), 32'h0);
        fifo_clr = 1'b1;
        tick();
        fifo_clr = 1'b0;

        // 2: full burst, cycle table
        write_words(32'h10, 8);
        beats.delete();
        for (int i = 0; i < 11; i++) begin
            en_i = vt[i].en;
            m_ready_i = vt[i].ready;
            #2;
            chk("tbl_busy", 32'(busy), 32'(vt[i].busy));
            chk("tbl_rd_valid", 32'(fifo_rd_valid), 32'(vt[i].rd));
            chk("tbl_m_valid", 32'(m_valid), 32'(vt[i].valid));
            chk("tbl_m_last", 32'(m_last), 32'(vt[i].last));
            chk("tbl_m_data", m_data, vt[i].data);
            chk("tbl_m_len", 32'(m_len), 32'(vt[i].len));
            tick();
        end
        chk("full_fifo_empty", 32'(fifo_empty), 32'h1);
        check_beats("full", 32'h10, 8, 8);

        // 3: timeout flush of three entries
        beats.delete();
        wr_en = 1'b1;
        wr_data = 32'h50;
        tick();
        n = 0;
        wr_data = 32'h51;
        tick();
        n++;
        wr_data = 32'h52;
        tick();
        n++;
        wr_en = 1'b0;
        while (!busy && n < 100) begin
            tick();
            n++;
        end
        chk("timeout_start_edges", 32'(n), 32'd64);
        wait_beats(3, 20);
        check_beats("timeout", 32'h50, 3, 3);

        // 4: backpressure with ready toggling
        en_i = 1'b0;
        beats.delete();
        write_words(32'h20, 8);
        en_i = 1'b1;
        n = 0;
        while (beats.size() < 8 && n < 80) begin
            m_ready_i = (n % 2 == 0);
            tick();
            n++;
        end
        m_ready_i = 1'b1;
        repeat (3) tick();
        check_beats("bp", 32'h20, 8, 8);
        chk("bp_fifo_count", 32'(fifo_counter), 32'd0);

        // 5: two back-to-back full bursts
        en_i = 1'b0;
        beats.delete();
        write_words(32'h30, 16);
        en_i = 1'b1;
        wait_beats(16, 60);
        check_beats("b2b", 32'h30, 16, 8);
        for (int i = 1; i < 16 && i < beats.size(); i++)
            chk("b2b_gap", 32'(beats[i].cyc - beats[i-1].cyc), (i == 8) ? 32'd2 : 32'd1);

        // flush request with two entries
        en_i = 1'b0;
        repeat (2) tick();
        beats.delete();
        write_words(32'h60, 2);
        flush_i = 1'b1;
        en_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_busy", 32'(busy), 32'h1);
        wait_beats(2, 20);
        check_beats("flush", 32'h60, 2, 2);

        // 6: reset asserted after three of eight beats
        en_i = 1'b0;
        repeat (2) tick();
        beats.delete();
        write_words(32'h40, 8);
        en_i = 1'b1;
        repeat (4) tick();
        chk("mid_m_data", m_data, 32'h42);
        chk("mid_fifo_count", 32'(fifo_counter), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_m_valid", 32'(m_valid), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_rd_valid", 32'(fifo_rd_valid), 32'h0);
        chk("mid_rst_m_data", m_data, 32'h0);
        repeat (3) tick();
        chk("mid_rst_fifo_count", 32'(fifo_counter), 32'd5);
        en_i = 1'b0;
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
